axi_lite_sram_slave: RTL and testbench

Parametrised AXI4-Lite slave wrapping a word-addressed on-chip SRAM, used as the data/instruction memory model behind the core's load/store and fetch units. Read and write channels run as independent state machines, so one read and one write can be in flight at the same time. The block supports AW and W arriving in either order and fixed or LFSR-randomised response latency. Addresses outside the mapped window return SLVERR.

---
 rtl/axi_lite_sram_slave.sv | 229 ++++++++++++++++++++++
 tb/tb_axi_lite_sram_slave.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_sram_slave.sv
// AXI4-Lite slave in front of a word-addressed SRAM. Independent read and write
// state machines; response latency is fixed or drawn from a free-running LFSR.
module axi_lite_sram_slave #(
   parameter int unsigned           DATA_WIDTH = 32,
   parameter int unsigned           ADDR_WIDTH = 32,
   parameter int unsigned           DEPTH      = 1024,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(32'h8000_0000),
   parameter bit                    RAND_LAT   = 1'b1,
   parameter int unsigned           FIXED_LAT  = 0,
   parameter logic [7:0]            LAT_MASK   = 8'h0F,
   parameter logic [7:0]            LFSR_SEED  = 8'hA5
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   // read address
   input  logic                    arvalid_i,
   output logic                    arready_o,
   input  logic [ADDR_WIDTH-1:0]   araddr_i,
   // read data
   output logic                    rvalid_o,
   input  logic                    rready_i,
   output logic [DATA_WIDTH-1:0]   rdata_o,
   output logic [1:0]              rresp_o,
   // write address
   input  logic                    awvalid_i,
   output logic                    awready_o,
   input  logic [ADDR_WIDTH-1:0]   awaddr_i,
   // write data
   input  logic                    wvalid_i,
   output logic                    wready_o,
   input  logic [DATA_WIDTH-1:0]   wdata_i,
   input  logic [DATA_WIDTH/8-1:0] wstrb_i,
   // write response
   output logic                    bvalid_o,
   input  logic                    bready_i,
   output logic [1:0]              bresp_o
);

   localparam int unsigned         BYTES = DATA_WIDTH / 8;
   localparam int unsigned         OFS_W = $clog2(BYTES);
   localparam int unsigned         IDX_W = $clog2(DEPTH);
   localparam logic [ADDR_WIDTH:0] SPAN  = (ADDR_WIDTH + 1)'(DEPTH * BYTES);

   typedef enum logic [1:0] {RIdle, RWait, RResp} rstate_e;
   typedef enum logic [1:0] {WIdle, WWait, WResp} wstate_e;

   // One extra bit keeps addresses below BASE_ADDR from wrapping into the window.
   function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
      logic [ADDR_WIDTH:0] off;
      off = {1'b0, a} - {1'b0, BASE_ADDR};
      return (a >= BASE_ADDR) && (off < SPAN);
   endfunction

   function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
      logic [ADDR_WIDTH-1:0] off;
      off = a - BASE_ADDR;
      return off[OFS_W +: IDX_W];
   endfunction

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   logic [7:0]            r_lfsr;
   logic                  r_active;
   logic [7:0]            w_lat;

   rstate_e               r_rstate, w_rstate_nxt;
   logic [7:0]            r_rcnt, w_rcnt_nxt;
   logic [ADDR_WIDTH-1:0] r_araddr;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic [1:0]            r_rresp;
   logic                  w_rd_fire;
   logic                  w_ar_hs;

   wstate_e               r_wstate, w_wstate_nxt;
   logic [7:0]            r_wcnt, w_wcnt_nxt;
   logic [ADDR_WIDTH-1:0] r_awaddr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [BYTES-1:0]      r_wstrb;
   logic                  r_aw_held, r_w_held;
   logic [1:0]            r_bresp;
   logic                  w_wr_fire;
   logic                  w_aw_hs, w_w_hs;

   assign w_lat = RAND_LAT ? (r_lfsr & LAT_MASK) : 8'(FIXED_LAT);

   assign arready_o = r_active && (r_rstate == RIdle);
   assign rvalid_o  = (r_rstate == RResp);
   assign rdata_o   = r_rdata;
   assign rresp_o   = r_rresp;

   assign awready_o = r_active && (r_wstate == WIdle) && !r_aw_held;
   assign wready_o  = r_active && (r_wstate == WIdle) && !r_w_held;
   assign bvalid_o  = (r_wstate == WResp);
   assign bresp_o   = r_bresp;

   assign w_ar_hs = arvalid_i && arready_o;
   assign w_aw_hs = awvalid_i && awready_o;
   assign w_w_hs  = wvalid_i && wready_o;

   // LFSR x^8+x^6+x^5+x^4+1 and the post-reset flag that holds readies low in reset.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         r_lfsr   <= LFSR_SEED;
         r_active <= 1'b0;
      end else begin
         r_lfsr   <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
         r_active <= 1'b1;
      end
   end

   // Read FSM next-state and latency countdown.
   always_comb begin
      w_rstate_nxt = r_rstate;
      w_rcnt_nxt   = r_rcnt;
      w_rd_fire    = 1'b0;
      case (r_rstate)
         RIdle: begin
            if (w_ar_hs) begin
               w_rcnt_nxt   = w_lat;
               w_rstate_nxt = RWait;
            end
         end
         RWait: begin
            if (r_rcnt != 8'd0) begin
               w_rcnt_nxt = r_rcnt - 8'd1;
            end else begin
               w_rd_fire    = 1'b1;
               w_rstate_nxt = RResp;
            end
         end
         RResp: begin
            if (rready_i) w_rstate_nxt = RIdle;
         end
         default: w_rstate_nxt = RIdle;
      endcase
   end

   // Read FSM state, captured address and registered response.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         r_rstate <= RIdle;
         r_rcnt   <= 8'd0;
         r_araddr <= '0;
         r_rdata  <= '0;
         r_rresp  <= 2'b00;
      end else begin
         r_rstate <= w_rstate_nxt;
         r_rcnt   <= w_rcnt_nxt;
         if (w_ar_hs) r_araddr <= araddr_i;
         if (w_rd_fire) begin
            if (in_range(r_araddr)) begin
               r_rdata <= r_mem[word_idx(r_araddr)];
               r_rresp <= 2'b00;
            end else begin
               r_rdata <= '0;
               r_rresp <= 2'b10;
            end
         end
      end
   end

   // Write FSM next-state; AW and W may be captured in either order or together.
   always_comb begin
      w_wstate_nxt = r_wstate;
      w_wcnt_nxt   = r_wcnt;
      w_wr_fire    = 1'b0;
      case (r_wstate)
         WIdle: begin
            if ((r_aw_held || w_aw_hs) && (r_w_held || w_w_hs)) begin
               w_wcnt_nxt   = w_lat;
               w_wstate_nxt = WWait;
            end
         end
         WWait: begin
            if (r_wcnt != 8'd0) begin
               w_wcnt_nxt = r_wcnt - 8'd1;
            end else begin
               w_wr_fire    = 1'b1;
               w_wstate_nxt = WResp;
            end
         end
         WResp: begin
            if (bready_i) w_wstate_nxt = WIdle;
         end
         default: w_wstate_nxt = WIdle;
      endcase
   end

   // Write FSM state, AW/W capture registers and registered response.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         r_wstate  <= WIdle;
         r_wcnt    <= 8'd0;
         r_awaddr  <= '0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
         r_aw_held <= 1'b0;
         r_w_held  <= 1'b0;
         r_bresp   <= 2'b00;
      end else begin
         r_wstate <= w_wstate_nxt;
         r_wcnt   <= w_wcnt_nxt;
         if (w_aw_hs) begin
            r_awaddr  <= awaddr_i;
            r_aw_held <= 1'b1;
         end
         if (w_w_hs) begin
            r_wdata  <= wdata_i;
            r_wstrb  <= wstrb_i;
            r_w_held <= 1'b1;
         end
         if ((r_wstate == WResp) && bready_i) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
         end
         if (w_wr_fire) r_bresp <= in_range(r_awaddr) ? 2'b00 : 2'b10;
      end
   end

   // SRAM byte-lane write; not reset, and a reset edge cancels a pending commit.
   always_ff @(posedge clk_i) begin
      if (rst_i && w_wr_fire && in_range(r_awaddr)) begin
         for (int unsigned b = 0; b < BYTES; b++) begin
            if (r_wstrb[b]) r_mem[word_idx(r_awaddr)][b*8 +: 8] <= r_wdata[b*8 +: 8];
         end
      end
   end

endmodule

// File: tb/tb_axi_lite_sram_slave.sv
// Directed self-checking bench for axi_lite_sram_slave with fixed latency 3.
module tb_axi_lite_sram_slave;

   localparam int unsigned FIXED_LAT = 3;
   localparam int unsigned DEPTH     = 1024;
   localparam logic [31:0] BASE      = 32'h8000_0000;
   localparam int          LAT       = FIXED_LAT + 1;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        arvalid = 1'b0, rready = 1'b0, awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0;
   logic [31:0] araddr = '0, awaddr = '0, wdata = '0;
   logic [3:0]  wstrb = '0;
   logic        arready_o, rvalid_o, awready_o, wready_o, bvalid_o;
   logic [31:0] rdata_o;
   logic [1:0]  rresp_o, bresp_o;

   int n_checks = 0;
   int n_err    = 0;
   int cyc      = 0;

   typedef struct packed {
      logic [31:0] data;
      logic [1:0]  resp;
   } rexp_t;

   rexp_t       rq[$];
   logic [1:0]  bq[$];
   logic [31:0] model[int];

   axi_lite_sram_slave #(
      .DATA_WIDTH (32),
      .ADDR_WIDTH (32),
      .DEPTH      (DEPTH),
      .BASE_ADDR  (BASE),
      .RAND_LAT   (1'b0),
      .FIXED_LAT  (FIXED_LAT),
      .LAT_MASK   (8'h0F),
      .LFSR_SEED  (8'hA5)
   ) dut (
      .clk_i     (clk),
      .rst_i     (rst_n),
      .arvalid_i (arvalid),
      .arready_o (arready_o),
      .araddr_i  (araddr),
      .rvalid_o  (rvalid_o),
      .rready_i  (rready),
      .rdata_o   (rdata_o),
      .rresp_o   (rresp_o),
      .awvalid_i (awvalid),
      .awready_o (awready_o),
      .awaddr_i  (awaddr),
      .wvalid_i  (wvalid),
      .wready_o  (wready_o),
      .wdata_i   (wdata),
      .wstrb_i   (wstrb),
      .bvalid_o  (bvalid_o),
      .bready_i  (bready),
      .bresp_o   (bresp_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit in_rng(input logic [31:0] a);
      return (a >= BASE) && ((a - BASE) < 32'(DEPTH * 4));
   endfunction

   function automatic int widx(input logic [31:0] a);
      return int'((a - BASE) >> 2);
   endfunction

   task automatic model_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] w;
      if (!in_rng(a)) return;
      w = model.exists(widx(a)) ? model[widx(a)] : 32'h0;
      for (int b = 0; b < 4; b++) if (s[b]) w[b*8 +: 8] = d[b*8 +: 8];
      model[widx(a)] = w;
   endtask

   task automatic push_b(input logic [31:0] a);
      bq.push_back(in_rng(a) ? 2'b00 : 2'b10);
   endtask

   task automatic push_r(input logic [31:0] a);
      rexp_t e;
      if (in_rng(a)) begin
         e.data = model.exists(widx(a)) ? model[widx(a)] : 32'h0;
         e.resp = 2'b00;
      end else begin
         e.data = 32'h0;
         e.resp = 2'b10;
      end
      rq.push_back(e);
   endtask

   task automatic send_aww(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output int hs);
      int  n = 0;
      bit  aw_go, w_go;
      awvalid = 1'b1; awaddr = a;
      wvalid  = 1'b1; wdata  = d; wstrb = s;
      while ((awvalid || wvalid) && n < 50) begin
         aw_go = awvalid && awready_o;
         w_go  = wvalid && wready_o;
         step();
         n++;
         if (aw_go) awvalid = 1'b0;
         if (w_go) wvalid = 1'b0;
      end
      check("aww_accept", {awvalid, wvalid}, 2'b00);
      awvalid = 1'b0;
      wvalid  = 1'b0;
      hs = cyc;
   endtask

   task automatic send_aw(input logic [31:0] a, output int hs);
      int n = 0;
      awvalid = 1'b1; awaddr = a;
      while (!awready_o && n < 50) begin step(); n++; end
      check("aw_accept", awready_o, 1);
      step();
      hs = cyc;
      awvalid = 1'b0;
   endtask

   task automatic send_w(input logic [31:0] d, input logic [3:0] s, output int hs);
      int n = 0;
      wvalid = 1'b1; wdata = d; wstrb = s;
      while (!wready_o && n < 50) begin step(); n++; end
      check("w_accept", wready_o, 1);
      step();
      hs = cyc;
      wvalid = 1'b0;
   endtask

   task automatic send_ar(input logic [31:0] a, output int hs);
      int n = 0;
      arvalid = 1'b1; araddr = a;
      while (!arready_o && n < 50) begin step(); n++; end
      check("ar_accept", arready_o, 1);
      step();
      hs = cyc;
      arvalid = 1'b0;
   endtask

   task automatic wait_b(input int hs, input string tag);
      int n = 0;
      while (!bvalid_o && n < 50) begin step(); n++; end
      check({tag, "_blat"}, 64'(cyc - hs), 64'(LAT));
      if (bq.size() == 0) begin
         n_checks++;
         n_err++;
         $error("FAIL %s_bsb: observed empty queue expected entry", tag);
      end else begin
         check({tag, "_bresp"}, bresp_o, bq.pop_front());
      end
      bready = 1'b1;
      step();
      bready = 1'b0;
      check({tag, "_bdone"}, {bvalid_o, awready_o, wready_o}, 3'b011);
   endtask

   task automatic wait_r(input int hs, input string tag);
      int    n = 0;
      rexp_t e;
      while (!rvalid_o && n < 50) begin step(); n++; end
      check({tag, "_rlat"}, 64'(cyc - hs), 64'(LAT));
      if (rq.size() == 0) begin
         n_checks++;
         n_err++;
         $error("FAIL %s_rsb: observed empty queue expected entry", tag);
      end else begin
         e = rq.pop_front();
         check({tag, "_rdata"}, rdata_o, e.data);
         check({tag, "_rresp"}, rresp_o, e.resp);
      end
      rready = 1'b1;
      step();
      rready = 1'b0;
      check({tag, "_rdone"}, {rvalid_o, arready_o}, 2'b01);
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input string tag);
      int h;
      push_b(a);
      model_wr(a, d, s);
      send_aww(a, d, s, h);
      wait_b(h, tag);
   endtask

   task automatic do_read(input logic [31:0] a, input string tag);
      int h;
      push_r(a);
      send_ar(a, h);
      wait_r(h, tag);
   endtask

   initial begin
      int    h;
      rexp_t er;
      logic [1:0] eb;

      // reset: one edge low, then release
      step();
      check("rst_out", {arready_o, awready_o, wready_o, rvalid_o, bvalid_o}, 5'b0);
      check("rst_data", {rdata_o, rresp_o, bresp_o}, 36'h0);
      rst_n = 1'b1;
      step();
      check("rst_release", {arready_o, awready_o, wready_o}, 3'b111);

      // fixed latency write then read
      do_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, "fix_w");
      do_read(32'h8000_0010, "fix_r");

      // byte strobes
      do_write(32'h8000_0020, 32'h1122_3344, 4'hF, "strb_init");
      do_write(32'h8000_0020, 32'hAABB_CCDD, 4'b0101, "strb_w");
      do_read(32'h8000_0020, "strb_r");

      // W ahead of AW
      send_w(32'hA5A5_0001, 4'hF, h);
      check("wfirst_held", {awready_o, wready_o}, 2'b10);
      repeat (4) step();
      check("wfirst_nob", {bvalid_o, wready_o}, 2'b00);
      push_b(32'h8000_0040);
      model_wr(32'h8000_0040, 32'hA5A5_0001, 4'hF);
      send_aw(32'h8000_0040, h);
      wait_b(h, "wfirst");

      // AW ahead of W
      send_aw(32'h8000_0044, h);
      check("awfirst_held", {awready_o, wready_o}, 2'b01);
      repeat (4) step();
      check("awfirst_nob", {bvalid_o, awready_o}, 2'b00);
      push_b(32'h8000_0044);
      model_wr(32'h8000_0044, 32'h5A5A_0002, 4'hF);
      send_w(32'h5A5A_0002, 4'hF, h);
      wait_b(h, "awfirst");
      do_read(32'h8000_0040, "wfirst_r");
      do_read(32'h8000_0044, "awfirst_r");

      // out of range must not alias onto word 0 or touch the last word
      do_write(32'h8000_0000, 32'h0BEE_F000, 4'hF, "w0_init");
      do_write(32'h8000_0FFC, 32'hCAFE_F00D, 4'hF, "last_init");
      do_write(32'h8000_1000, 32'hFFFF_FFFF, 4'hF, "oor_w");
      do_read(32'h8000_1000, "oor_r");
      do_read(32'h8000_0FFC, "last_r");
      do_read(32'h8000_0000, "w0_r");

      // concurrent read and write to one word with backpressure; read sees old data
      push_r(32'h8000_0010);
      push_b(32'h8000_0010);
      model_wr(32'h8000_0010, 32'h1234_5678, 4'hF);
      arvalid = 1'b1; araddr = 32'h8000_0010;
      awvalid = 1'b1; awaddr = 32'h8000_0010;
      wvalid  = 1'b1; wdata  = 32'h1234_5678; wstrb = 4'hF;
      check("conc_ready", {arready_o, awready_o, wready_o}, 3'b111);
      step();
      h = cyc;
      arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
      repeat (LAT - 1) step();
      check("conc_early", {rvalid_o, bvalid_o}, 2'b00);
      step();
      check("conc_lat", 64'(cyc - h), 64'(LAT));
      er = rq.pop_front();
      eb = bq.pop_front();
      for (int i = 0; i < 10; i++) begin
         check("conc_hold", {rvalid_o, bvalid_o, arready_o, awready_o, rresp_o, rdata_o, bresp_o},
               {4'b1100, er.resp, er.data, eb});
         step();
      end
      rready = 1'b1;
      bready = 1'b1;
      step();
      rready = 1'b0;
      bready = 1'b0;
      check("conc_done", {rvalid_o, bvalid_o, arready_o, awready_o}, 4'b0011);
      do_read(32'h8000_0010, "conc_r");

      // reset during W_WAIT aborts the write
      do_write(32'h8000_0030, 32'h5555_5555, 4'hF, "rstw_init");
      send_aww(32'h8000_0030, 32'h0BAD_F00D, 4'hF, h);
      step();
      rst_n = 1'b0;
      step();
      check("rstw_in_rst", {arready_o, awready_o, wready_o, bvalid_o}, 4'b0000);
      rst_n = 1'b1;
      step();
      check("rstw_ready", {arready_o, awready_o, wready_o}, 3'b111);
      for (int i = 0; i < 8; i++) begin
         check("rstw_nob", bvalid_o, 0);
         step();
      end
      do_read(32'h8000_0030, "rstw_r");

      check("sb_empty", {32'(rq.size()), 32'(bq.size())}, 64'h0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule
